// File: rtl/clock_pkg.sv
// clock_pkg
// Shared definitions for the digital clock's mode sequencer: the MODO
// encodings seen by the display/control multiplexer, the FSM state type
// (kept as plain 2-bit constants so the state value is the MODO value),
// and the mode-advance helper.
package clock_pkg;

  localparam logic [1:0] MODE_HORA      = 2'b00;
  localparam logic [1:0] MODE_AJ_HORA   = 2'b01;
  localparam logic [1:0] MODE_AJ_ALARMA = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t S_HORA      = MODE_HORA;
  localparam state_t S_AJ_HORA   = MODE_AJ_HORA;
  localparam state_t S_AJ_ALARMA = MODE_AJ_ALARMA;

  // Mode button order: time -> adjust time -> adjust alarm -> time.
  // The unused encoding falls back to time display.
  function automatic state_t next_mode(input state_t s);
    case (s)
      S_HORA:      next_mode = S_AJ_HORA;
      S_AJ_HORA:   next_mode = S_AJ_ALARMA;
      default:     next_mode = S_HORA;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchronizer, tick-sampled debouncer and rising-edge event for
// one raw push-button.
//
// Ports:
//   clk    in  system clock, all state on rising edge
//   rst_n  in  asynchronous active-low reset
//   tick   in  one-cycle sampling enable (once per millisecond)
//   btn    in  raw asynchronous button level, active-high
//   db     out debounced level
//   rise   out one-cycle pulse in the cycle after db goes 0 -> 1
//
// Parameter:
//   DEB_MS consecutive disagreeing tick samples required before db follows
module btn_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic db,
  output logic rise
);

  localparam int CW = $clog2(DEB_MS + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          db_reg;
  logic          rise_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      db_reg    <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      if (tick) begin
        if (sync2_reg == db_reg) begin
          // Any agreeing sample restarts the stability window.
          cnt_reg <= '0;
        end else if (cnt_reg == CW'(DEB_MS - 1)) begin
          // This is the DEB_MS-th consecutive disagreeing sample.
          db_reg   <= sync2_reg;
          rise_reg <= sync2_reg;
          cnt_reg  <= '0;
        end else if (cnt_reg != CW'(DEB_MS)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign db   = db_reg;
  assign rise = rise_reg;

endmodule

// File: rtl/clock_mode_sequencer.sv
// clock_mode_sequencer
// Debounces the MODE/MIN/HR front-panel buttons and runs the display mode
// FSM (time -> adjust time -> adjust alarm), producing the MODO select,
// the AJH/AJA adjust enables and one-cycle AUM/AUH increment strobes. An
// inactivity timeout in either adjust mode returns to time display.
//
// Ports:
//   CLK       in  system clock
//   RST_N     in  asynchronous active-low reset
//   TICK_MS   in  one-cycle enable, once per millisecond
//   BTN_MODE  in  raw mode button (active-high, asynchronous)
//   BTN_MIN   in  raw minute-increment button
//   BTN_HR    in  raw hour-increment button
//   MODO      out 00 time, 01 adjust time, 10 adjust alarm
//   AJH       out high in adjust-time mode
//   AJA       out high in adjust-alarm mode
//   AUM       out one-cycle minute-increment strobe
//   AUH       out one-cycle hour-increment strobe
//
// Optional feature: define CLOCK_MODE_AUTOREPEAT_EN to auto-repeat a held
// MIN/HR button (first repeat REP_DELAY_MS ticks after the press strobe,
// then every REP_RATE_MS ticks). Without it each press yields one strobe.
module clock_mode_sequencer
  import clock_pkg::*;
#(
  parameter int DEB_MS       = 20,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100,
  parameter int TIMEOUT_MS   = 10000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK_MS,
  input  logic       BTN_MODE,
  input  logic       BTN_MIN,
  input  logic       BTN_HR,
  output logic [1:0] MODO,
  output logic       AJH,
  output logic       AJA,
  output logic       AUM,
  output logic       AUH
);

  localparam int TO_W = $clog2(TIMEOUT_MS + 1);

  // Increment buttons are handled as a 2-bit vector: bit 0 MIN, bit 1 HR.
  logic            mode_db;
  logic            mode_ev;
  logic [1:0]      inc_db;
  logic [1:0]      inc_ev;
  logic [1:0]      press_fire;
  logic [1:0]      rep_fire;
  logic [1:0]      strobe_next;

  state_t          state_reg;
  state_t          state_next;
  logic [TO_W-1:0] inact_reg;
  logic [TO_W-1:0] inact_next;
  logic            aum_reg;
  logic            auh_reg;

  logic            in_adj;
  logic            activity;
  logic            timeout_hit;
  logic            state_change;

  btn_debounce #(.DEB_MS(DEB_MS)) u_mode (
    .clk   (CLK),
    .rst_n (RST_N),
    .tick  (TICK_MS),
    .btn   (BTN_MODE),
    .db    (mode_db),
    .rise  (mode_ev)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_min (
    .clk   (CLK),
    .rst_n (RST_N),
    .tick  (TICK_MS),
    .btn   (BTN_MIN),
    .db    (inc_db[0]),
    .rise  (inc_ev[0])
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_hr (
    .clk   (CLK),
    .rst_n (RST_N),
    .tick  (TICK_MS),
    .btn   (BTN_HR),
    .db    (inc_db[1]),
    .rise  (inc_ev[1])
  );

  // The mode level itself is never needed (mode never repeats), and the
  // increment levels only feed the optional repeat logic.
  logic unused_inputs;
  assign unused_inputs = ^{mode_db, inc_db} ^ (REP_DELAY_MS > REP_RATE_MS);

  assign in_adj = (state_reg != S_HORA);

  // A mode press in the same cycle wins: the transition is taken and any
  // increment strobe is dropped.
  assign press_fire   = (in_adj && !mode_ev) ? inc_ev : 2'b00;
  assign strobe_next  = press_fire | rep_fire;
  assign activity     = mode_ev | (|inc_ev) | (|rep_fire);
  // Fire on the tick that would bring the count to TIMEOUT_MS so MODO
  // returns to time display right after that tick.
  assign timeout_hit  = in_adj && TICK_MS && !activity &&
                        (inact_reg == TO_W'(TIMEOUT_MS - 1));
  assign state_change = mode_ev | timeout_hit;

  always_comb begin
    state_next = state_reg;
    if (mode_ev) begin
      state_next = next_mode(state_reg);
    end else if (timeout_hit) begin
      state_next = S_HORA;
    end
  end

  always_comb begin
    inact_next = inact_reg;
    if (activity || state_change) begin
      inact_next = '0;
    end else if (TICK_MS && in_adj && (inact_reg != TO_W'(TIMEOUT_MS))) begin
      inact_next = inact_reg + 1'b1;
    end
  end

`ifdef CLOCK_MODE_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY_MS > REP_RATE_MS) ? REP_DELAY_MS : REP_RATE_MS;
  localparam int RW      = $clog2(REP_MAX + 1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_rep
    logic          armed_reg;
    logic          first_reg;
    logic [RW-1:0] rep_cnt_reg;
    logic [RW-1:0] rep_target;

    // first_reg selects the initial hold delay, afterwards the repeat period.
    assign rep_target   = first_reg ? RW'(REP_DELAY_MS - 1) : RW'(REP_RATE_MS - 1);
    assign rep_fire[gi] = armed_reg && inc_db[gi] && TICK_MS && in_adj &&
                          !mode_ev && (rep_cnt_reg == rep_target);

    // Only a press strobe issued in an adjust state arms the repeat; any
    // state change or release disarms it, so a button still held across a
    // mode change stays silent until it is pressed again.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        armed_reg   <= 1'b0;
        first_reg   <= 1'b0;
        rep_cnt_reg <= '0;
      end else if (state_change || !inc_db[gi]) begin
        armed_reg   <= 1'b0;
        first_reg   <= 1'b0;
        rep_cnt_reg <= '0;
      end else if (press_fire[gi]) begin
        armed_reg   <= 1'b1;
        first_reg   <= 1'b1;
        rep_cnt_reg <= '0;
      end else if (rep_fire[gi]) begin
        first_reg   <= 1'b0;
        rep_cnt_reg <= '0;
      end else if (armed_reg && TICK_MS && !(&rep_cnt_reg)) begin
        rep_cnt_reg <= rep_cnt_reg + 1'b1;
      end
    end
  end
`else
  for (genvar gi = 0; gi < 2; gi++) begin : g_rep
    assign rep_fire[gi] = 1'b0;
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_HORA;
      inact_reg <= '0;
      aum_reg   <= 1'b0;
      auh_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      inact_reg <= inact_next;
      aum_reg   <= strobe_next[0];
      auh_reg   <= strobe_next[1];
    end
  end

  // Decoded straight from the state register, so no input-to-output path.
  assign MODO = state_reg;
  assign AJH  = (state_reg == S_AJ_HORA);
  assign AJA  = (state_reg == S_AJ_ALARMA);
  assign AUM  = aum_reg;
  assign AUH  = auh_reg;

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// tb_clock_mode_sequencer
// Directed bench for clock_mode_sequencer with DEB_MS=4, REP_DELAY_MS=10,
// REP_RATE_MS=3, TIMEOUT_MS=50. One TICK_MS pulse every 5 clock cycles.
module tb_clock_mode_sequencer;

  logic       CLK      = 1'b0;
  logic       RST_N    = 1'b0;
  logic       TICK_MS  = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic       BTN_MIN  = 1'b0;
  logic       BTN_HR   = 1'b0;
  logic [1:0] MODO;
  logic       AJH;
  logic       AJA;
  logic       AUM;
  logic       AUH;

  int errors   = 0;
  int checks   = 0;
  int tick_idx = 0;

  int aum_cnt      = 0;
  int auh_cnt      = 0;
  int both_cnt     = 0;
  int consec_cnt   = 0;
  int modo_changes = 0;
  logic       prev_aum  = 1'b0;
  logic       prev_auh  = 1'b0;
  logic [1:0] prev_modo = 2'b00;
  int auh_ticks[$];

  always #5 CLK = ~CLK;

  clock_mode_sequencer #(
    .DEB_MS       (4),
    .REP_DELAY_MS (10),
    .REP_RATE_MS  (3),
    .TIMEOUT_MS   (50)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .TICK_MS  (TICK_MS),
    .BTN_MODE (BTN_MODE),
    .BTN_MIN  (BTN_MIN),
    .BTN_HR   (BTN_HR),
    .MODO     (MODO),
    .AJH      (AJH),
    .AJA      (AJA),
    .AUM      (AUM),
    .AUH      (AUH)
  );

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (AUM) aum_cnt++;
    if (AUH) begin
      auh_cnt++;
      auh_ticks.push_back(tick_idx);
    end
    if (AUM && AUH) both_cnt++;
    if ((AUM && prev_aum) || (AUH && prev_auh)) consec_cnt++;
    if (MODO != prev_modo) modo_changes++;
    prev_aum  = AUM;
    prev_auh  = AUH;
    prev_modo = MODO;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      TICK_MS = 1'b1;
      tick_idx++;
      @(negedge CLK);
      TICK_MS = 1'b0;
      repeat (3) @(negedge CLK);
    end
  endtask

  // Let a new raw level pass the synchronizer before the next tick.
  task automatic settle();
    repeat (3) @(negedge CLK);
  endtask

  // Drive raw levels and give exactly DEB_MS ticks: db rises on the last one.
  task automatic press(input logic m, input logic mi, input logic h);
    BTN_MODE = m;
    BTN_MIN  = mi;
    BTN_HR   = h;
    settle();
    ticks(4);
  endtask

  task automatic release_all();
    BTN_MODE = 1'b0;
    BTN_MIN  = 1'b0;
    BTN_HR   = 1'b0;
    settle();
    ticks(4);
  endtask

  initial begin
    int base;
    int exp_off[$];
    int n;

    // ---- reset state
    repeat (3) @(negedge CLK);
    chk("rst_modo", 32'(MODO), 0);
    chk("rst_ajh",  32'(AJH),  0);
    chk("rst_aja",  32'(AJA),  0);
    chk("rst_aum",  32'(AUM),  0);
    chk("rst_auh",  32'(AUH),  0);
    RST_N = 1'b1;
    settle();

    // ---- bounce rejection: toggle for 3 ticks, then steady high
    BTN_MODE = 1'b1; settle(); ticks(1);
    BTN_MODE = 1'b0; settle(); ticks(1);
    BTN_MODE = 1'b1; settle(); ticks(1);
    chk("bounce_no_early", 32'(MODO), 0);
    ticks(4);
    chk("bounce_modo", 32'(MODO), 1);
    chk("bounce_ajh",  32'(AJH),  1);
    chk("bounce_one_transition", 32'(modo_changes), 1);
    release_all();
    chk("release_no_event", 32'(MODO), 1);

    // ---- mode cycling (continues from adjust time)
    press(1, 0, 0);
    chk("cycle_modo_10", 32'(MODO), 2);
    chk("cycle_aja_10",  32'(AJA),  1);
    chk("cycle_ajh_10",  32'(AJH),  0);
    release_all();
    press(1, 0, 0);
    chk("cycle_modo_00", 32'(MODO), 0);
    chk("cycle_aja_00",  32'(AJA),  0);
    release_all();

    // ---- increment gating
    press(0, 1, 0);
    chk("min_in_hora_no_aum", 32'(aum_cnt), 0);
    chk("min_in_hora_no_mode", 32'(MODO), 0);
    release_all();
    press(1, 0, 0);
    chk("enter_aj_hora", 32'(MODO), 1);
    release_all();
    press(0, 1, 0);
    chk("min_in_adj_aum", 32'(aum_cnt), 1);
    release_all();
    press(0, 1, 1);
    chk("both_same_cycle", 32'(both_cnt), 1);
    chk("both_aum_total", 32'(aum_cnt), 2);
    chk("both_auh_total", 32'(auh_cnt), 1);
    release_all();

    // ---- mode + MIN together: transition wins, strobe suppressed
    press(1, 1, 0);
    chk("mode_min_modo", 32'(MODO), 2);
    chk("mode_min_no_aum", 32'(aum_cnt), 2);
    release_all();                         // ticks 1..4 since entry
    ticks(45);                             // tick 49
    chk("timeout_not_yet", 32'(MODO), 2);
    ticks(1);                              // tick 50
    chk("timeout_to_hora", 32'(MODO), 0);

    // ---- timeout restarted by a press at tick 40
    press(1, 0, 0);
    release_all();
    press(1, 0, 0);
    chk("restart_enter_alarm", 32'(MODO), 2);
    release_all();                         // ticks 1..4
    ticks(36);                             // tick 40
    press(0, 1, 0);                        // press event after tick 44
    chk("restart_aum_in_alarm", 32'(aum_cnt), 3);
    release_all();
    ticks(45);                             // 49 ticks after the press
    chk("restart_still_alarm", 32'(MODO), 2);
    ticks(1);
    chk("restart_timeout", 32'(MODO), 0);

    // ---- auto-repeat on a held HR button in adjust time
    press(1, 0, 0);
    release_all();
    chk("rep_enter_aj_hora", 32'(MODO), 1);
    auh_ticks.delete();
    press(0, 0, 1);
    base = tick_idx;
    ticks(17);
    BTN_HR = 1'b0;
    settle();
    ticks(6);
`ifdef CLOCK_MODE_AUTOREPEAT_EN
    exp_off = '{0, 10, 13, 16, 19};
`else
    exp_off = '{0};
`endif
    chk("rep_strobe_count", 32'(auh_ticks.size()), 32'(exp_off.size()));
    n = (auh_ticks.size() < exp_off.size()) ? auh_ticks.size() : exp_off.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rep_offset_%0d", i), 32'(auh_ticks[i] - base), 32'(exp_off[i]));
    end
    chk("rep_mode_kept", 32'(MODO), 1);
    chk("no_back_to_back_strobe", 32'(consec_cnt), 0);

    // ---- reset mid-adjust, mode button held through release
    chk("pre_reset_ajh", 32'(AJH), 1);
    @(negedge CLK);
    BTN_MODE = 1'b1;
    RST_N    = 1'b0;
    #1;
    chk("async_rst_modo", 32'(MODO), 0);
    chk("async_rst_ajh",  32'(AJH),  0);
    chk("async_rst_aum",  32'(AUM),  0);
    chk("async_rst_auh",  32'(AUH),  0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    settle();
    ticks(3);
    chk("post_rst_hora", 32'(MODO), 0);
    ticks(1);
    chk("held_press_after_rst", 32'(MODO), 1);
    release_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
